// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcodes, FSM state encoding and opcode check for the serial ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_alu_sequencer_if.sv
// ============================================================================
// Module  : serial_alu_sequencer_if
// Brief   : Request/result bundle between a requester and the serial ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero, err
  );
endinterface

`default_nettype wire

// File: rtl/one_bit_alu.sv
// ============================================================================
// Module  : one_bit_alu
// Brief   : One-bit ALU slice: AND/OR/add/less select with optional B invert.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module one_bit_alu (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       r,
  output logic       cout
);

  logic w_b;
  logic w_sum;

  assign w_b   = b ^ op[2];
  assign w_sum = a ^ w_b ^ cin;
  assign cout  = (a & w_b) | (a & cin) | (w_b & cin);

  always_comb begin
    r = 1'b0;
    case (op[1:0])
      2'b00:   r = a & w_b;
      2'b01:   r = a | w_b;
      2'b10:   r = w_sum;
      default: r = less;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_alu_sequencer.sv
// ============================================================================
// Module  : serial_alu_sequencer
// Brief   : Bit-serial ALU front end driving one one_bit_alu slice LSB first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_alu_sequencer_if.slave  bus
);

  state_t           state;
  state_t           state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_sh;

  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;
  logic             err_q;

  logic             slice_r;
  logic             slice_cout;
  logic             last_bit;
  logic             slt_set;
  logic [WIDTH-1:0] final_res;

  one_bit_alu u_slice (
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .cin  (carry),
    .less (1'b0),
    .op   (op_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Sign of a-b corrected for overflow, using the carry out of the top bit.
  assign slt_set = a_q[WIDTH-1] ^ ~b_q[WIDTH-1] ^ slice_cout;

  always_comb begin
    final_res            = result_sh;
    final_res[WIDTH-1]   = slice_r;
    if (op_q == OP_SLT) begin
      final_res = {{(WIDTH-1){1'b0}}, slt_set};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = is_legal_op(bus.op) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      carry     <= 1'b0;
      cnt       <= '0;
      result_sh <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (is_legal_op(bus.op)) begin
              a_q   <= bus.a;
              b_q   <= bus.b;
              op_q  <= bus.op;
              carry <= bus.op[2];
              cnt   <= '0;
            end else begin
              result_q <= '0;
              cout_q   <= 1'b0;
              zero_q   <= 1'b1;
              err_q    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          result_sh[cnt] <= slice_r;
          carry          <= slice_cout;
          cnt            <= cnt + CNT_W'(1);
          if (last_bit) begin
            result_q <= final_res;
            // Only the arithmetic ops (op[1]=1) expose a carry.
            cout_q   <= op_q[1] & slice_cout;
            zero_q   <= (final_res == '0);
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == S_RUN);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;
  assign bus.err    = err_q;

endmodule

`default_nettype wire
